// File: rtl/frequency_ratio_meter.sv
// Measures period and high time of a slow, asynchronous square wave in clk cycles,
// with lock detection (two equal consecutive periods) and loss-of-signal timeout.
module frequency_ratio_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d_q;
  logic                   rise_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             have_prev_q, have_prev_d;

  assign s = sync_q[SYNC_STAGES-1];

  // The edge strobe is registered; s_d_q is the level aligned with rise_q, so the
  // high-time count sees the same sample stream the edge detector saw.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
      rise_q <= s & ~s_d_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    wait_d      = wait_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;

    if (!enable) begin
      state_d     = StIdle;
      cnt_d       = '0;
      hcnt_d      = '0;
      wait_d      = '0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
          hcnt_d  = '0;
          wait_d  = One;
        end
        StArm: begin
          if (rise_q) begin
            state_d   = StMeasure;
            cnt_d     = One;
            hcnt_d    = One;
            timeout_d = 1'b0;
          end else if (wait_q == TimeoutVal) begin
            // Wait counter saturates; timeout stays up until the next rise.
            timeout_d = 1'b1;
            locked_d  = 1'b0;
          end else begin
            wait_d = wait_q + One;
          end
        end
        StMeasure: begin
          if (rise_q) begin
            period_d    = cnt_q;
            high_d      = hcnt_q;
            valid_d     = 1'b1;
            locked_d    = have_prev_q && (cnt_q == period_q);
            have_prev_d = 1'b1;
            cnt_d       = One;
            hcnt_d      = One;
            timeout_d   = 1'b0;
          end else if (cnt_q == TimeoutVal) begin
            state_d     = StArm;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
            hcnt_d      = '0;
            wait_d      = One;
          end else begin
            cnt_d = cnt_q + One;
            if (s_d_q) begin
              hcnt_d = hcnt_q + One;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      wait_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      wait_q      <= wait_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
